// File: rtl/nand_array_pipe.sv
// nand_array_pipe: registered WIDTH-bit bitwise logic array with run-time op select.
// Each result is written, together with its popcount, into a DEPTH-entry show-ahead
// FIFO drained through a valid/ready handshake.
module nand_array_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           y,
  output logic [$clog2(WIDTH+1)-1:0] ones
);

  localparam int ONES_W = $clog2(WIDTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_BUFA = 3'b111;

  logic [WIDTH-1:0]  r_mem_y    [DEPTH];
  logic [ONES_W-1:0] r_mem_ones [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [WIDTH-1:0]  w_res;
  logic [ONES_W-1:0] w_pop;
  logic              w_empty;
  logic              w_push;
  logic              w_pop_fire;

  // Bitwise op decode; NAND is the legacy default.
  always_comb begin
    w_res = ~(a & b);
    case (op)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_XOR:  w_res = a ^ b;
      OP_XNOR: w_res = ~(a ^ b);
      OP_NOTA: w_res = ~a;
      OP_BUFA: w_res = a;
      default: w_res = ~(a & b);
    endcase
  end

  // Popcount of the result, stored alongside it so the output side stays a plain mux.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + ONES_W'(w_res[i]);
    end
  end

  // Flow control derived from registered occupancy only (no pass-through when full).
  always_comb begin
    w_empty    = (r_count == '0);
    in_ready   = (r_count != CNT_W'(DEPTH));
    out_valid  = !w_empty;
    w_push     = in_valid && in_ready;
    w_pop_fire = out_valid && out_ready;
  end

  // Show-ahead head presentation; zeros when empty.
  always_comb begin
    y    = '0;
    ones = '0;
    if (!w_empty) begin
      y    = r_mem_y[r_rptr];
      ones = r_mem_ones[r_rptr];
    end
  end

  // FIFO storage write; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_y[r_wptr]    <= w_res;
      r_mem_ones[r_wptr] <= w_pop;
    end
  end

  // Pointer and occupancy update; reset discards any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop_fire) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop_fire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop_fire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/nand_array_pipe.md
Name: nand_array_pipe

Overview:
- Parametrised, registered successor to the single 2-input gate: a WIDTH-bit bitwise logic array with a run-time op select.
- Results are buffered in a DEPTH-entry output FIFO behind a valid/ready handshake.
- Each result carries a population count of its set bits.
- Sits between stimulus sources (switches, registers) and display/consumer logic on the FPGA board designs.

Parameters:
- WIDTH, 8, bits per operand/result; 1..32.
- DEPTH, 2, output FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  source presents a, b, op.
- in_ready  out  1  block can accept this cycle.
- op  in  3  operation select (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result at FIFO head is valid.
- out_ready  in  1  consumer takes result this cycle.
- y  out  WIDTH  result at FIFO head.
- ones  out  $clog2(WIDTH+1)  count of 1 bits in y.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only at the rising edge of clk.
- Op encoding: 000 AND, 001 OR, 010 NAND (default / legacy function), 011 NOR, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 BUF a (b ignored). All ops are bitwise across WIDTH.
- Accept and pop:
  - Accept: in_valid & in_ready at a rising edge. The result f(op, a, b) and its popcount are written into the FIFO tail.
  - Pop: out_valid & out_ready at a rising edge. The head entry is removed.
- Show-ahead output:
  - y and ones present the head entry combinationally from FIFO storage.
  - When empty, out_valid=0, y=0, ones=0.
- Latency: an input accepted at edge t is visible at edge t+1 (out_valid=1 in cycle t+1) if the FIFO was empty. Otherwise it appears in order behind older entries. No combinational path from a/b/op to y.
- Flow control:
  - in_ready = (count != DEPTH), derived from registered count only.
  - No pass-through when full: when full, in_ready=0 even if out_ready=1.
- Simultaneous accept and pop (count between 1 and DEPTH-1, or full with pop only): count unchanged on accept+pop, both pointers advance.
- Empty with pop attempt: ignored (out_valid=0, so no pop).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Data stability: y/ones are held while out_valid=1 and out_ready=0. Entries are never overwritten or dropped.
- Reset:
  - When rst_n=0 at an edge: count=0, pointers=0, out_valid=0, y=0, ones=0, and in_ready=1 from the next cycle.
  - Any handshake in that same cycle is discarded.
  - Reset mid-operation flushes all buffered results.
  - FIFO storage contents need not be cleared.
- Popcount is computed on the result before the FIFO write, and is stored with it.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 edges, release -> out_valid=0, y=8'h00, ones=0, in_ready=1.
- NAND single transfer: a=8'hF0, b=8'hCC, op=010, 1-cycle in_valid, out_ready=1 -> next cycle out_valid=1, y=8'h3F, ones=6; following cycle out_valid=0.
- All ops sweep: a=8'hA5, b=8'h0F, ops 000..111 back-to-back with out_ready=1 -> y sequence 05, AF, FA, 50, AA, 55, 5A, A5. ones sequence 2, 6, 6, 2, 4, 4, 4, 4. One result per cycle, in order.
- Backpressure/full: out_ready=0, push three requests (AND of FF/01, FF/02, FF/04):
  - in_ready drops after 2 accepts; third request held.
  - y stays 01.
  - Then out_ready=1 -> outputs 01, 02, 04 in order, none lost.
- Simultaneous push/pop at count=1: steady in_valid=out_ready=1 for 10 cycles -> count stays 1, 10 results delivered in order.
- Reset mid-flight: FIFO holding 2 entries, assert rst_n=0 for one edge -> out_valid=0 next cycle, old entries never appear, and the next accepted input is delivered first.
